// File: rtl/s_xfer_sched.sv
// s_xfer_sched: sequences ROUNDS block transfers on the shared S1/S2 serial pair.
// Latency: start accepted on the next edge; each transfer costs GAP reset cycles plus the
//          WAIT time (up to TMO cycles), with one NEXT cycle between consecutive transfers.
// Backpressure: start is ignored while a run is in flight (ARM/WAIT/NEXT); no stall inputs.
//
// Ports:
//   clk, rst           - rising-edge clock, asynchronous active-high reset
//   start, mode        - one-cycle run request; direction pattern latched on acceptance
//   S1_done, S2_done   - completion flags from the two serial units, sampled only in WAIT
//   updown, slave_rst  - direction and reset driven to both serial units
//   busy, run_done,
//   err_tmo, xfer_cnt  - run status and completed-transfer count
module s_xfer_sched #(
  parameter int ROUNDS = 4,    // transfers per run, 1..15
  parameter int GAP    = 2,    // slave_rst cycles in ARM before each transfer, >= 1
  parameter int TMO    = 200   // max WAIT cycles before timeout, <= 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       S1_done,
  input  logic       S2_done,
  output logic       updown,
  output logic       slave_rst,
  output logic       busy,
  output logic       run_done,
  output logic       err_tmo,
  output logic [3:0] xfer_cnt
);

  localparam int             GW       = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0]  GAP_LD   = GW'(GAP);
  localparam logic [GW-1:0]  GAP_LAST = GW'(1);
  localparam logic [7:0]     TMO_LAST = 8'(TMO - 1);
  localparam logic [4:0]     ROUNDS_W = 5'(ROUNDS);
  localparam logic [3:0]     CNT_MAX  = 4'(ROUNDS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    WAIT = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [7:0]    tmo_cnt, tmo_nxt;
  logic [3:0]    cnt_nxt;
  logic          ud_nxt;
  logic [1:0]    mode_q, mode_nxt;

  // Status outputs are pure decodes of the state register, so they reset
  // together with it and can never disagree with the sequencing.
  assign slave_rst = (state != WAIT);
  assign busy      = (state == ARM) || (state == WAIT) || (state == NEXT);
  assign run_done  = (state == DONE);
  assign err_tmo   = (state == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      tmo_cnt  <= '0;
      xfer_cnt <= '0;
      updown   <= 1'b1;
      mode_q   <= 2'd0;
    end else begin
      state    <= state_nxt;
      gap_cnt  <= gap_nxt;
      tmo_cnt  <= tmo_nxt;
      xfer_cnt <= cnt_nxt;
      updown   <= ud_nxt;
      mode_q   <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    tmo_nxt   = tmo_cnt;
    cnt_nxt   = xfer_cnt;
    ud_nxt    = updown;
    mode_nxt  = mode_q;

    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          mode_nxt  = mode;
          cnt_nxt   = '0;
          // Modes 0/1 start up (1), modes 2/3 start down (0).
          ud_nxt    = ~mode[1];
          gap_nxt   = GAP_LD;
          state_nxt = ARM;
        end
      end

      ARM: begin
        // The cycle that sees a count of 1 is the last reset cycle, giving
        // exactly GAP cycles of slave_rst before the slaves are released.
        if (gap_cnt <= GAP_LAST) begin
          tmo_nxt   = '0;
          state_nxt = WAIT;
        end else begin
          gap_nxt = gap_cnt - GAP_LAST;
        end
      end

      WAIT: begin
        // Joint completion is tested first so it wins over a coincident timeout.
        if (S1_done && S2_done) begin
          state_nxt = NEXT;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ERR;
        end else begin
          tmo_nxt = tmo_cnt + 8'd1;
        end
      end

      NEXT: begin
        if (xfer_cnt != CNT_MAX) begin
          cnt_nxt = xfer_cnt + 4'd1;
        end
        if (({1'b0, xfer_cnt} + 5'd1) >= ROUNDS_W) begin
          state_nxt = DONE;
        end else begin
          // Patterns 0 (00) and 3 (11) alternate; 1 and 2 keep direction.
          if (mode_q[0] == mode_q[1]) begin
            ud_nxt = ~updown;
          end
          gap_nxt   = GAP_LD;
          state_nxt = ARM;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_s_xfer_sched.sv
// tb_s_xfer_sched: randomized scoreboard bench for s_xfer_sched.
// Latency: n/a (bench); expected transfer/end records are queued before each start.
// Backpressure: n/a; a responder models S1/S2 done flags per transfer.
module tb_s_xfer_sched;

  localparam int ROUNDS = 4;
  localparam int GAP    = 2;
  localparam int TMO    = 200;
  localparam int NEVER  = 1000;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       S1_done;
  logic       S2_done;
  logic       updown;
  logic       slave_rst;
  logic       busy;
  logic       run_done;
  logic       err_tmo;
  logic [3:0] xfer_cnt;

  s_xfer_sched #(.ROUNDS(ROUNDS), .GAP(GAP), .TMO(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .S1_done  (S1_done),
    .S2_done  (S2_done),
    .updown   (updown),
    .slave_rst(slave_rst),
    .busy     (busy),
    .run_done (run_done),
    .err_tmo  (err_tmo),
    .xfer_cnt (xfer_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected per-transfer observation and per-run ending.
  typedef struct {
    logic ud;     // direction during the transfer
    int   gap;    // busy cycles with slave_rst high before release
    int   wlen;   // cycles slave_rst stays low
    int   cnt;    // xfer_cnt when the transfer starts
  } xrec_t;

  typedef struct {
    logic rd;
    logic et;
    int   cnt;
    logic ud;
  } erec_t;

  xrec_t xq[$];
  erec_t eq[$];

  int run_s1 [16];   // cycles after release before S1_done rises, per transfer
  int run_s2 [16];
  int bound_miss;
  bit finish_req;

  int checks;
  int errors;

  // ---------------- reference model ----------------
  function automatic logic dir_of(input logic [1:0] m, input int i);
    case (m)
      2'd0:    return (i % 2) == 0;
      2'd1:    return 1'b1;
      2'd2:    return 1'b0;
      default: return (i % 2) == 1;
    endcase
  endfunction

  task automatic model(input logic [1:0] m);
    xrec_t x;
    erec_t e;
    int    d;
    for (int i = 0; i < ROUNDS; i++) begin
      d      = (run_s1[i] > run_s2[i]) ? run_s1[i] : run_s2[i];
      x.ud   = dir_of(m, i);
      x.gap  = (i == 0) ? GAP : GAP + 1;
      x.wlen = (d < TMO) ? d + 1 : TMO;
      x.cnt  = i;
      xq.push_back(x);
      if (d >= TMO) begin
        e.rd = 1'b0; e.et = 1'b1; e.cnt = i; e.ud = dir_of(m, i);
        eq.push_back(e);
        return;
      end
    end
    e.rd = 1'b1; e.et = 1'b0; e.cnt = ROUNDS; e.ud = dir_of(m, ROUNDS - 1);
    eq.push_back(e);
  endtask

  // ---------------- S1/S2 responder ----------------
  initial begin
    int tidx;
    int lo;
    tidx = 0; lo = 0;
    S1_done = 1'b0; S2_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !busy) begin
        tidx = 0; lo = 0;
        S1_done = 1'b0; S2_done = 1'b0;
      end else if (slave_rst) begin
        if (lo > 0 && tidx < 15) tidx++;
        lo = 0;
        S1_done = 1'b0; S2_done = 1'b0;
      end else begin
        S1_done = (lo >= run_s1[tidx]);
        S2_done = (lo >= run_s2[tidx]);
        lo++;
      end
    end
  end

  // ---------------- monitor / checker ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic  prev_srst, prev_busy, ud_fall;
    int    hi, lo;
    xrec_t x;
    erec_t e;
    checks = 0; errors = 0;
    prev_srst = 1'b1; prev_busy = 1'b0; ud_fall = 1'b0;
    hi = 0; lo = 0;
    forever begin
      @(negedge clk);
      if (finish_req) begin
        chk("xfer_queue_drained", xq.size(), 0);
        chk("end_queue_drained", eq.size(), 0);
        chk("run_bound_misses", bound_miss, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end else if (rst) begin
        chk("rst_updown", updown, 1);
        chk("rst_slave_rst", slave_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_run_done", run_done, 0);
        chk("rst_err_tmo", err_tmo, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        prev_srst = 1'b1; prev_busy = 1'b0; hi = 0; lo = 0;
      end else begin
        if (!prev_busy && busy) begin
          hi = 0;
          chk("start_run_done_clr", run_done, 0);
          chk("start_err_tmo_clr", err_tmo, 0);
        end
        if (busy && slave_rst) hi++;
        if (prev_srst && !slave_rst) begin
          if (xq.size() == 0) begin
            chk("unexpected_transfer", 1, 0);
          end else begin
            x = xq[0];
            chk("xfer_updown", updown, x.ud);
            chk("xfer_gap", hi, x.gap);
            chk("xfer_cnt_at_start", xfer_cnt, x.cnt);
          end
          ud_fall = updown;
          hi = 0; lo = 0;
        end
        if (!slave_rst) lo++;
        if (!prev_srst && slave_rst) begin
          if (xq.size() == 0) begin
            chk("unexpected_release_end", 1, 0);
          end else begin
            x = xq.pop_front();
            chk("wait_len", lo, x.wlen);
            chk("updown_stable_in_wait", updown, ud_fall);
          end
        end
        if (prev_busy && !busy) begin
          if (eq.size() == 0) begin
            chk("unexpected_run_end", 1, 0);
          end else begin
            e = eq.pop_front();
            chk("end_run_done", run_done, e.rd);
            chk("end_err_tmo", err_tmo, e.et);
            chk("end_xfer_cnt", xfer_cnt, e.cnt);
            chk("end_updown", updown, e.ud);
            chk("end_slave_rst", slave_rst, 1);
          end
        end
        prev_srst = slave_rst;
        prev_busy = busy;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_all(input int d);
    for (int i = 0; i < 16; i++) begin
      run_s1[i] = d;
      run_s2[i] = d;
    end
  endtask

  task automatic run(input logic [1:0] m, input bit noise);
    bit ended;
    model(m);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = 2'($urandom);   // must not matter once latched
    ended = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      start = noise && ($urandom_range(0, 4) == 0);
    end
    start = 1'b0;
    if (!ended) bound_miss++;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int d;
    rst = 1'b1; start = 1'b0; mode = 2'd0;
    finish_req = 1'b0; bound_miss = 0;
    set_all(10);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic patterns, done 10 cycles after release.
    set_all(10); run(2'd0, 1'b0);
    set_all(10); run(2'd2, 1'b0);
    set_all(10); run(2'd1, 1'b0);
    set_all(10); run(2'd3, 1'b0);

    // S2 never answers on the second transfer: timeout after one completion.
    set_all(10); run_s2[1] = NEVER; run(2'd0, 1'b0);

    // S1 alone for 5 cycles before S2 joins.
    set_all(10); run_s1[2] = 3; run_s2[2] = 8; run(2'd1, 1'b0);

    // Completion on the last permitted WAIT cycle, then one cycle too late.
    set_all(6); run_s1[1] = TMO - 1; run_s2[1] = TMO - 1; run(2'd3, 1'b0);
    set_all(6); run_s1[0] = TMO; run(2'd2, 1'b0);

    // Start pulses while busy must be ignored.
    set_all(12); run(2'd0, 1'b1);

    // Reset mid-WAIT, then a clean run.
    set_all(100);
    model(2'd3);
    mode = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && slave_rst; c++) @(negedge clk);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    xq.delete();
    eq.delete();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    set_all(9); run(2'd0, 1'b0);

    // Randomized runs.
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 16; i++) begin
        run_s1[i] = $urandom_range(1, 25);
        run_s2[i] = $urandom_range(1, 25);
        if ($urandom_range(0, 11) == 0) begin
          d = $urandom_range(0, 2);
          run_s2[i] = (d == 0) ? TMO - 1 : (d == 1) ? TMO : NEVER;
        end
      end
      run(2'($urandom), bit'($urandom_range(0, 1)));
    end

    finish_req = 1'b1;
  end

endmodule
